// File: rtl/decode_window_ctrl_pkg.sv
// rtl/decode_window_ctrl_pkg.sv - shared constants, prefix byte codes and state encoding for the decode window
package decode_window_ctrl_pkg;

  localparam int DEF_WIN_BYTES   = 12;
  localparam int DEF_MAX_INS_LEN = 15;

  localparam logic [7:0] PFX_LOCK   = 8'hF0;
  localparam logic [7:0] PFX_REPNE  = 8'hF2;
  localparam logic [7:0] PFX_REP    = 8'hF3;
  localparam logic [7:0] PFX_ES     = 8'h26;
  localparam logic [7:0] PFX_CS     = 8'h2E;
  localparam logic [7:0] PFX_SS     = 8'h36;
  localparam logic [7:0] PFX_DS     = 8'h3E;
  localparam logic [7:0] PFX_FS     = 8'h64;
  localparam logic [7:0] PFX_GS     = 8'h65;
  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_ADSIZE = 8'h67;
  localparam logic [7:0] PFX_ESC    = 8'h0F;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_F3   = 2'b01;
  localparam logic [1:0] REP_F2   = 2'b10;

  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  function automatic logic is_prefix_byte(input logic [7:0] b);
    case (b)
      PFX_LOCK, PFX_REPNE, PFX_REP, PFX_ES, PFX_CS, PFX_SS, PFX_DS,
      PFX_FS, PFX_GS, PFX_OPSIZE, PFX_ADSIZE, PFX_ESC: is_prefix_byte = 1'b1;
      default:                                         is_prefix_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_window_shifter.sv
// rtl/decode_window_shifter.sv - byte shift-down of the decode window plus append at a byte offset, zero fill
module decode_window_shifter
  import decode_window_ctrl_pkg::*;
#(
  parameter int WIN_BYTES = DEF_WIN_BYTES
) (
  input  logic [8*WIN_BYTES-1:0] i_win,
  input  logic [3:0]             i_shift,
  input  logic [4:0]             i_base,
  input  logic                   i_app_en,
  input  logic [31:0]            i_app_data,
  input  logic [2:0]             i_app_len,
  output logic [8*WIN_BYTES-1:0] o_win
);

  logic [8*WIN_BYTES-1:0] w_shifted;

  // Logical shift zero-fills the vacated upper bytes.
  assign w_shifted = i_win >> {i_shift, 3'b000};

  always_comb begin
    o_win = w_shifted;
    for (int j = 0; j < WIN_BYTES; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (i_app_en && (k < int'(i_app_len)) && (int'(i_base) + k == j)) begin
          o_win[8*j +: 8] = i_app_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/decode_window_ctrl.sv
// rtl/decode_window_ctrl.sv - decode window sequencer: fill, prefix absorb, consume and length limit
// Optional AO486_DEC_PERF_EN adds perf_clear / perf_ins_count / perf_prefix_count.
module decode_window_ctrl
  import decode_window_ctrl_pkg::*;
#(
  parameter int WIN_BYTES   = DEF_WIN_BYTES,
  parameter int MAX_INS_LEN = DEF_MAX_INS_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dec_reset,
  input  logic [31:0]            prefetch_data,
  input  logic [2:0]             prefetch_length,
  input  logic                   prefetch_valid,
  output logic                   prefetch_accept,
  output logic [8*WIN_BYTES-1:0] decoder,
  output logic                   dec_window_valid,
  input  logic                   consume_valid,
  input  logic [3:0]             consume_len,
  input  logic                   micro_busy,
  output logic                   prefix_group_1_lock,
  output logic [1:0]             dec_prefix_group_1_rep,
  output logic                   dec_prefix_2byte,
  output logic                   dec_operand_32bit,
  output logic                   dec_address_32bit,
  output logic [2:0]             dec_segment,
  output logic                   dec_segment_valid,
  input  logic                   protected_mode,
  output logic                   dec_valid,
  output logic [3:0]             dec_ins_len,
  output logic                   dec_gp_fault
`ifdef AO486_DEC_PERF_EN
  ,
  input  logic                   perf_clear,
  output logic [31:0]            perf_ins_count,
  output logic [31:0]            perf_prefix_count
`endif
);

  state_t                 r_state;
  logic [8*WIN_BYTES-1:0] r_window;
  logic [4:0]             r_count;
  logic [3:0]             r_ins_len;
  logic                   r_lock, r_2byte, r_opsize, r_adsize, r_segv, r_dec_valid;
  logic [1:0]             r_rep;
  logic [2:0]             r_seg;
  logic [3:0]             r_dec_ins_len;

  logic [7:0]             w_byte0;
  logic                   w_is_prefix, w_win_valid, w_accept, w_consume, w_absorb;
  logic                   w_consume_fault, w_absorb_fault, w_fault;
  logic [4:0]             w_total;
  logic [3:0]             w_shift;
  logic [4:0]             w_count_post, w_count_next;
  logic [8*WIN_BYTES-1:0] w_window_next;

  assign w_byte0 = r_window[7:0];
  // The byte following a 0F escape is an opcode even if it looks like a prefix.
  assign w_is_prefix = (r_state == ST_RUN) && (r_count != 5'd0) && !r_2byte && is_prefix_byte(w_byte0);
  assign w_win_valid = (r_state == ST_RUN) && (r_count != 5'd0) && !w_is_prefix && !micro_busy;
  assign w_accept    = (r_state == ST_RUN) && prefetch_valid && !dec_reset &&
                       ((r_count + {2'b00, prefetch_length}) <= 5'(WIN_BYTES));
  assign w_consume   = w_win_valid && consume_valid && !dec_reset;
  assign w_absorb    = w_is_prefix && !dec_reset;

  assign w_total         = {1'b0, r_ins_len} + {1'b0, consume_len};
  assign w_consume_fault = w_consume && (w_total > 5'(MAX_INS_LEN));
  assign w_absorb_fault  = w_absorb && (({1'b0, r_ins_len} + 5'd1) == 5'(MAX_INS_LEN));
  assign w_fault         = w_consume_fault || w_absorb_fault;

  assign w_shift      = w_consume ? consume_len : (w_absorb ? 4'd1 : 4'd0);
  assign w_count_post = r_count - {1'b0, w_shift};
  assign w_count_next = w_count_post + (w_accept ? {2'b00, prefetch_length} : 5'd0);

  decode_window_shifter #(.WIN_BYTES(WIN_BYTES)) u_shifter (
    .i_win      (r_window),
    .i_shift    (w_shift),
    .i_base     (w_count_post),
    .i_app_en   (w_accept),
    .i_app_data (prefetch_data),
    .i_app_len  (prefetch_length),
    .o_win      (w_window_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;       r_window <= '0;        r_count <= 5'd0;
      r_ins_len <= 4'd0;       r_lock <= 1'b0;        r_rep <= REP_NONE;
      r_2byte <= 1'b0;         r_opsize <= 1'b0;      r_adsize <= 1'b0;
      r_seg <= SEG_ES;         r_segv <= 1'b0;        r_dec_valid <= 1'b0;
      r_dec_ins_len <= 4'd0;
    end else if (dec_reset) begin
      r_state <= ST_RUN;       r_window <= '0;        r_count <= 5'd0;
      r_ins_len <= 4'd0;       r_lock <= 1'b0;        r_rep <= REP_NONE;
      r_2byte <= 1'b0;         r_opsize <= 1'b0;      r_adsize <= 1'b0;
      r_seg <= SEG_ES;         r_segv <= 1'b0;        r_dec_valid <= 1'b0;
    end else if (r_state == ST_FAULT || w_fault) begin
      // Everything freezes until a flush; only the state moves.
      r_state     <= ST_FAULT;
      r_dec_valid <= 1'b0;
    end else begin
      r_window    <= w_window_next;
      r_count     <= w_count_next;
      r_dec_valid <= w_consume;
      if (w_consume) begin
        r_dec_ins_len <= w_total[3:0];
        r_ins_len <= 4'd0;     r_lock <= 1'b0;        r_rep <= REP_NONE;
        r_2byte <= 1'b0;       r_opsize <= 1'b0;      r_adsize <= 1'b0;
        r_seg <= SEG_ES;       r_segv <= 1'b0;
      end else if (w_absorb) begin
        r_ins_len <= r_ins_len + 4'd1;
        case (w_byte0)
          PFX_LOCK:   r_lock   <= 1'b1;
          PFX_REPNE:  r_rep    <= REP_F2;
          PFX_REP:    r_rep    <= REP_F3;
          PFX_ES:     begin r_seg <= SEG_ES; r_segv <= 1'b1; end
          PFX_CS:     begin r_seg <= SEG_CS; r_segv <= 1'b1; end
          PFX_SS:     begin r_seg <= SEG_SS; r_segv <= 1'b1; end
          PFX_DS:     begin r_seg <= SEG_DS; r_segv <= 1'b1; end
          PFX_FS:     begin r_seg <= SEG_FS; r_segv <= 1'b1; end
          PFX_GS:     begin r_seg <= SEG_GS; r_segv <= 1'b1; end
          PFX_OPSIZE: r_opsize <= 1'b1;
          PFX_ADSIZE: r_adsize <= 1'b1;
          PFX_ESC:    r_2byte  <= 1'b1;
          default:    ;
        endcase
      end
    end
  end

`ifdef AO486_DEC_PERF_EN
  logic        w_absorb_ok;
  logic [31:0] r_perf_ins, r_perf_pfx;

  assign w_absorb_ok = w_absorb && !w_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ins <= 32'd0;
      r_perf_pfx <= 32'd0;
    end else if (perf_clear) begin
      r_perf_ins <= 32'd0;
      r_perf_pfx <= 32'd0;
    end else begin
      if (r_dec_valid) r_perf_ins <= r_perf_ins + 32'd1;
      if (w_absorb_ok) r_perf_pfx <= r_perf_pfx + 32'd1;
    end
  end

  assign perf_ins_count    = r_perf_ins;
  assign perf_prefix_count = r_perf_pfx;
`endif

  assign prefetch_accept        = w_accept;
  assign decoder                = r_window;
  assign dec_window_valid       = w_win_valid;
  assign prefix_group_1_lock    = r_lock;
  assign dec_prefix_group_1_rep = r_rep;
  assign dec_prefix_2byte       = r_2byte;
  assign dec_operand_32bit      = protected_mode ^ r_opsize;
  assign dec_address_32bit      = protected_mode ^ r_adsize;
  assign dec_segment            = r_seg;
  assign dec_segment_valid      = r_segv;
  assign dec_valid              = r_dec_valid;
  assign dec_ins_len            = r_dec_ins_len;
  assign dec_gp_fault           = (r_state == ST_FAULT);

endmodule

// File: tb/tb_decode_window_ctrl.sv
// tb/tb_decode_window_ctrl.sv - queue-model checked bench for decode_window_ctrl, directed plus random
module tb_decode_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, dec_reset, prefetch_valid, prefetch_accept, dec_window_valid;
  logic [31:0] prefetch_data;
  logic [2:0]  prefetch_length;
  logic [95:0] decoder;
  logic        consume_valid, micro_busy, prefix_group_1_lock, dec_prefix_2byte;
  logic [3:0]  consume_len, dec_ins_len;
  logic [1:0]  dec_prefix_group_1_rep;
  logic        dec_operand_32bit, dec_address_32bit, dec_segment_valid, protected_mode;
  logic [2:0]  dec_segment;
  logic        dec_valid, dec_gp_fault;

  decode_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dec_reset(dec_reset),
    .prefetch_data(prefetch_data), .prefetch_length(prefetch_length),
    .prefetch_valid(prefetch_valid), .prefetch_accept(prefetch_accept),
    .decoder(decoder), .dec_window_valid(dec_window_valid),
    .consume_valid(consume_valid), .consume_len(consume_len), .micro_busy(micro_busy),
    .prefix_group_1_lock(prefix_group_1_lock), .dec_prefix_group_1_rep(dec_prefix_group_1_rep),
    .dec_prefix_2byte(dec_prefix_2byte), .dec_operand_32bit(dec_operand_32bit),
    .dec_address_32bit(dec_address_32bit), .dec_segment(dec_segment),
    .dec_segment_valid(dec_segment_valid), .protected_mode(protected_mode),
    .dec_valid(dec_valid), .dec_ins_len(dec_ins_len), .dec_gp_fault(dec_gp_fault)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the window is a byte queue; prefix state is plain flags.
  logic [7:0]  q[$];
  int          m_ins;
  logic        m_lock, m_esc, m_op, m_ad, m_segv, m_fault, m_dv, m_freeze;
  logic [1:0]  m_rep;
  logic [2:0]  m_seg;
  logic [3:0]  m_dil;
  logic        e_pfx, e_wv, e_acc;
  logic [95:0] e_win;

  function automatic logic is_pfx(input logic [7:0] b);
    return b inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E,
                     8'h64, 8'h65, 8'h66, 8'h67, 8'h0F};
  endfunction

  task automatic clear_prefixes();
    m_ins = 0; m_lock = 0; m_rep = 2'b00; m_esc = 0; m_op = 0; m_ad = 0;
    m_segv = 0; m_seg = 3'd0;
  endtask

  task automatic apply_prefix(input logic [7:0] b);
    case (b)
      8'hF0: m_lock = 1;
      8'hF2: m_rep = 2'b10;
      8'hF3: m_rep = 2'b01;
      8'h26: begin m_seg = 3'd0; m_segv = 1; end
      8'h2E: begin m_seg = 3'd1; m_segv = 1; end
      8'h36: begin m_seg = 3'd2; m_segv = 1; end
      8'h3E: begin m_seg = 3'd3; m_segv = 1; end
      8'h64: begin m_seg = 3'd4; m_segv = 1; end
      8'h65: begin m_seg = 3'd5; m_segv = 1; end
      8'h66: m_op = 1;
      8'h67: m_ad = 1;
      default: m_esc = 1;
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete(); clear_prefixes(); m_fault = 0; m_dv = 0; m_dil = 4'd0;
    end else begin
      e_pfx = !m_fault && (q.size() > 0) && !m_esc && is_pfx(q[0]);
      e_wv  = !m_fault && (q.size() > 0) && !e_pfx && !micro_busy;
      e_acc = !m_fault && prefetch_valid && !dec_reset && (q.size() + int'(prefetch_length) <= 12);
      e_win = '0;
      foreach (q[i]) e_win[8*i +: 8] = q[i];
      check("accept", 96'(prefetch_accept), 96'(e_acc));
      check("win_valid", 96'(dec_window_valid), 96'(e_wv));
      check("decoder", decoder, e_win);
      check("dec_valid", 96'(dec_valid), 96'(m_dv));
      if (m_dv) check("ins_len", 96'(dec_ins_len), 96'(m_dil));
      check("gp_fault", 96'(dec_gp_fault), 96'(m_fault));
      check("lock", 96'(prefix_group_1_lock), 96'(m_lock));
      check("rep", 96'(dec_prefix_group_1_rep), 96'(m_rep));
      check("esc", 96'(dec_prefix_2byte), 96'(m_esc));
      check("op32", 96'(dec_operand_32bit), 96'(protected_mode ^ m_op));
      check("ad32", 96'(dec_address_32bit), 96'(protected_mode ^ m_ad));
      check("segv", 96'(dec_segment_valid), 96'(m_segv));
      if (m_segv) check("seg", 96'(dec_segment), 96'(m_seg));

      if (dec_reset) begin
        q.delete(); clear_prefixes(); m_fault = 0; m_dv = 0;
      end else if (m_fault) begin
        m_dv = 0;
      end else begin
        m_dv = 0; m_freeze = 0;
        if (e_wv && consume_valid) begin
          if (m_ins + int'(consume_len) > 15) begin
            m_fault = 1; m_freeze = 1;
          end else begin
            m_dv = 1; m_dil = 4'(m_ins + int'(consume_len));
            for (int i = 0; i < int'(consume_len); i++) if (q.size() > 0) void'(q.pop_front());
            clear_prefixes();
          end
        end else if (e_pfx) begin
          if (m_ins + 1 == 15) begin
            m_fault = 1; m_freeze = 1;
          end else begin
            apply_prefix(q[0]); m_ins++; void'(q.pop_front());
          end
        end
        if (!m_freeze && e_acc)
          for (int k = 0; k < int'(prefetch_length); k++) q.push_back(prefetch_data[8*k +: 8]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    prefetch_valid = 0; prefetch_data = 32'd0; prefetch_length = 3'd1;
    consume_valid = 0; consume_len = 4'd1; micro_busy = 0; dec_reset = 0;
  endtask

  task automatic flush();
    idle(); dec_reset = 1; step(); dec_reset = 0;
  endtask

  task automatic feed(input logic [7:0] s[$], input logic [3:0] cl, input int cycles,
                      output int n_dv, output logic [3:0] last_len, output logic saw_fault);
    int p;
    p = 0; n_dv = 0; last_len = 4'd0; saw_fault = 0;
    consume_valid = 1; consume_len = cl;
    repeat (cycles) begin
      int n;
      n = s.size() - p;
      if (n > 4) n = 4;
      prefetch_data = 32'd0;
      if (n > 0) begin
        prefetch_valid = 1; prefetch_length = 3'(n);
        for (int k = 0; k < n; k++) prefetch_data[8*k +: 8] = s[p+k];
      end else prefetch_valid = 0;
      #2;
      if (prefetch_valid && prefetch_accept) p += n;
      step();
      if (dec_valid) begin n_dv++; last_len = dec_ins_len; end
      if (dec_gp_fault) saw_fault = 1;
    end
    idle();
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] tbl [12];
    tbl = '{8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67, 8'h0F};
    if ($urandom_range(0, 5) == 0) return tbl[$urandom_range(0, 11)];
    return 8'($urandom_range(0, 255));
  endfunction

  logic [7:0] s[$];
  int         n_dv;
  logic [3:0] last_len;
  logic       saw_fault;

  initial begin
    rst_n = 0; protected_mode = 0; idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    prefetch_valid = 1; prefetch_data = 32'h90909090; prefetch_length = 3'd4; micro_busy = 1;
    #1;
    check("rst_decoder", decoder, 96'd0);
    check("rst_dec_valid", 96'(dec_valid), 96'd0);
    check("rst_gp_fault", 96'(dec_gp_fault), 96'd0);
    check("rst_win_valid", 96'(dec_window_valid), 96'd0);
    check("fill_accept_empty", 96'(prefetch_accept), 96'd1);
    step(); step(); step();
    check("fill_full_window", decoder, 96'h909090909090909090909090);
    check("fill_accept_full", 96'(prefetch_accept), 96'd0);
    flush();

    prefetch_valid = 1; prefetch_data = 32'h00A5F366; prefetch_length = 3'd3;
    consume_valid = 1; consume_len = 4'd1;
    step(); prefetch_valid = 0;
    check("pfx_window", decoder, 96'hA5F366);
    check("pfx_not_valid", 96'(dec_window_valid), 96'd0);
    step(); step();
    check("pfx_rep", 96'(dec_prefix_group_1_rep), 96'b01);
    check("pfx_op32", 96'(dec_operand_32bit), 96'd1);
    check("pfx_opcode_valid", 96'(dec_window_valid), 96'd1);
    step();
    check("pfx_dec_valid", 96'(dec_valid), 96'd1);
    check("pfx_ins_len", 96'(dec_ins_len), 96'd3);
    check("pfx_rep_cleared", 96'(dec_prefix_group_1_rep), 96'd0);
    check("pfx_op_cleared", 96'(dec_operand_32bit), 96'd0);
    flush();

    prefetch_valid = 1; prefetch_data = 32'h00C0B60F; prefetch_length = 3'd3;
    consume_valid = 1; consume_len = 4'd2;
    step(); prefetch_valid = 0;
    step();
    check("esc_flag", 96'(dec_prefix_2byte), 96'd1);
    check("esc_window", decoder, 96'hC0B6);
    step();
    check("esc_ins_len", 96'(dec_ins_len), 96'd3);
    check("esc_dec_valid", 96'(dec_valid), 96'd1);
    flush();

    s = {}; repeat (14) s.push_back(8'h26); s.push_back(8'h90);
    feed(s, 4'd1, 30, n_dv, last_len, saw_fault);
    check("len15_dv_count", 96'(n_dv), 96'd1);
    check("len15_ins_len", 96'(last_len), 96'd15);
    check("len15_no_fault", 96'(saw_fault), 96'd0);
    flush();
    s = {}; repeat (14) s.push_back(8'h26); s.push_back(8'h90); s.push_back(8'h90);
    feed(s, 4'd2, 30, n_dv, last_len, saw_fault);
    check("len16_no_dv", 96'(n_dv), 96'd0);
    check("len16_fault", 96'(saw_fault), 96'd1);
    check("len16_fault_held", 96'(dec_gp_fault), 96'd1);
    flush();
    check("fault_exit_gp", 96'(dec_gp_fault), 96'd0);
    check("fault_exit_window", decoder, 96'd0);
    s = {}; repeat (15) s.push_back(8'h26);
    feed(s, 4'd1, 30, n_dv, last_len, saw_fault);
    check("pfx15_fault", 96'(saw_fault), 96'd1);
    check("pfx15_no_dv", 96'(n_dv), 96'd0);
    flush();

    prefetch_valid = 1; prefetch_length = 3'd4; prefetch_data = 32'h03020100;
    step(); prefetch_data = 32'h07060504;
    step(); prefetch_data = 32'h0B0A0908; consume_valid = 1; consume_len = 4'd5;
    step(); idle();
    check("simul_window", decoder, 96'h00000000_000B0A09_08070605);
    check("simul_ins_len", 96'(dec_ins_len), 96'd5);
    flush();

    prefetch_valid = 1; prefetch_length = 3'd4; prefetch_data = 32'h90909090;
    step(); prefetch_valid = 0; micro_busy = 1; consume_valid = 1; consume_len = 4'd1;
    #1;
    check("busy_win_valid", 96'(dec_window_valid), 96'd0);
    step();
    check("busy_no_dv", 96'(dec_valid), 96'd0);
    check("busy_window_kept", decoder, 96'h90909090);
    flush();
    prefetch_valid = 1; prefetch_length = 3'd4; prefetch_data = 32'h9026F366;
    step(); prefetch_valid = 0;
    step(); step();
    check("flush_pre_rep", 96'(dec_prefix_group_1_rep), 96'b01);
    dec_reset = 1;
    step(); dec_reset = 0;
    check("flush_rep", 96'(dec_prefix_group_1_rep), 96'd0);
    check("flush_op32", 96'(dec_operand_32bit), 96'd0);
    check("flush_window", decoder, 96'd0);

    repeat (3000) begin
      prefetch_valid  = ($urandom_range(0, 3) != 0);
      prefetch_length = 3'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) prefetch_data[8*k +: 8] = rnd_byte();
      consume_valid   = $urandom_range(0, 1) != 0;
      consume_len     = (q.size() > 0) ? 4'($urandom_range(1, q.size())) : 4'd1;
      micro_busy      = ($urandom_range(0, 7) == 0);
      dec_reset       = ($urandom_range(0, 60) == 0);
      protected_mode  = $urandom_range(0, 1) != 0;
      step();
    end
    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
